// File: rtl/rom_sweep_checker.sv
// ROM sweep-and-verify engine: sweeps [start..end] with wrap-around, then either
// compares every word to a reference or folds all words into a rotate-XOR signature.
module rom_sweep_checker #(
    parameter int ADDR_WIDTH    = 8,
    parameter int DATA_WIDTH    = 96,
    parameter int RD_LATENCY    = 1,
    parameter int ERR_CNT_WIDTH = 3
) (
    input  logic                     clk,
    input  logic                     tb_rst,
    input  logic                     i_start,
    input  logic                     i_cmp_mode,
    input  logic [ADDR_WIDTH-1:0]    i_start_addr,
    input  logic [ADDR_WIDTH-1:0]    i_end_addr,
    input  logic [DATA_WIDTH-1:0]    i_expect_data,
    output logic [ADDR_WIDTH-1:0]    o_rom_addr,
    output logic                     o_rom_rd_en,
    input  logic [DATA_WIDTH-1:0]    i_rom_rd_data,
    output logic                     o_busy,
    output logic                     o_done,
    output logic [ERR_CNT_WIDTH-1:0] o_err_cnt,
    output logic                     o_first_err_valid,
    output logic [ADDR_WIDTH-1:0]    o_first_err_addr,
    output logic [DATA_WIDTH-1:0]    o_signature
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SWEEP,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam logic [1:0] DRAIN_LAST = 2'(RD_LATENCY - 1);

    state_t                  r_state;
    logic                    r_mode;
    logic [ADDR_WIDTH-1:0]   r_end_addr;
    logic [1:0]              r_drain_cnt;
    logic [RD_LATENCY-1:0]   r_tag_vld;
    logic [ADDR_WIDTH-1:0]   r_tag_addr [RD_LATENCY];

    logic                    w_launch;
    logic                    w_tag_vld;
    logic [ADDR_WIDTH-1:0]   w_tag_addr;
    logic                    w_mismatch;

    assign w_launch   = (r_state == ST_IDLE) && i_start;
    assign w_tag_vld  = r_tag_vld[RD_LATENCY-1];
    assign w_tag_addr = r_tag_addr[RD_LATENCY-1];
    assign w_mismatch = (i_rom_rd_data != i_expect_data);

    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            r_state     <= ST_IDLE;
            r_mode      <= 1'b0;
            r_end_addr  <= '0;
            r_drain_cnt <= '0;
            o_rom_addr  <= '0;
            o_rom_rd_en <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_mode      <= i_cmp_mode;
                        r_end_addr  <= i_end_addr;
                        r_drain_cnt <= '0;
                        o_rom_addr  <= i_start_addr;
                        o_rom_rd_en <= 1'b1;
                        o_busy      <= 1'b1;
                        r_state     <= ST_SWEEP;
                    end
                end
                ST_SWEEP: begin
                    o_rom_addr <= o_rom_addr + 1'b1;
                    if (o_rom_addr == r_end_addr) begin
                        o_rom_rd_en <= 1'b0;
                        r_state     <= ST_DRAIN;
                    end
                end
                // One DRAIN cycle per pipeline stage so the last tag is consumed as done rises.
                ST_DRAIN: begin
                    if (r_drain_cnt == DRAIN_LAST) begin
                        o_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    o_done  <= 1'b0;
                    o_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            r_tag_vld <= '0;
        end else if (w_launch) begin
            r_tag_vld <= '0;
        end else begin
            r_tag_vld[0] <= o_rom_rd_en;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_tag_vld[i] <= r_tag_vld[i-1];
            end
        end
    end

    // NOTE: the tag address needs no reset; it is only ever used qualified by its valid bit.
    always_ff @(posedge clk) begin
        r_tag_addr[0] <= o_rom_addr;
        for (int i = 1; i < RD_LATENCY; i++) begin
            r_tag_addr[i] <= r_tag_addr[i-1];
        end
    end

    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            o_err_cnt         <= '0;
            o_first_err_valid <= 1'b0;
            o_first_err_addr  <= '0;
            o_signature       <= '0;
        end else if (w_launch) begin
            o_err_cnt         <= '0;
            o_first_err_valid <= 1'b0;
            o_first_err_addr  <= '0;
            o_signature       <= '0;
        end else if (w_tag_vld) begin
            if (r_mode) begin
                o_signature <= {o_signature[DATA_WIDTH-2:0], o_signature[DATA_WIDTH-1]} ^ i_rom_rd_data;
            end else if (w_mismatch) begin
                if (o_err_cnt != '1) begin
                    o_err_cnt <= o_err_cnt + 1'b1;
                end
                if (!o_first_err_valid) begin
                    o_first_err_valid <= 1'b1;
                    o_first_err_addr  <= w_tag_addr;
                end
            end
        end
    end

endmodule
